// File: rtl/step1_fetch_pkg.sv
// step1_fetch_pkg: shared definitions for the instruction-fetch stage.
//   - fetch FSM state encoding
//   - PC width and default reset PC / increment
package step1_fetch_pkg;

    localparam int          PC_W         = 16;
    localparam logic [15:0] DEF_RESET_PC = 16'h0000;
    localparam logic [15:0] DEF_PC_INC   = 16'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/step1_fetch_if.sv
// step1_fetch_if: request/ready instruction-memory bus.
//   memReq   fetch stage -> memory : request pending
//   memAddr  fetch stage -> memory : fetch address
//   memReady memory -> fetch stage : memData valid this cycle
//   memData  memory -> fetch stage : instruction word
// master = fetch stage, slave = instruction memory.
interface step1_fetch_if;
    import step1_fetch_pkg::*;

    logic            memReq;
    logic [PC_W-1:0] memAddr;
    logic            memReady;
    logic [15:0]     memData;

    modport master (output memReq, memAddr, input  memReady, memData);
    modport slave  (input  memReq, memAddr, output memReady, memData);
endinterface

// File: rtl/step1_fetch_pc_reg.sv
// fetch_pc_reg: program counter register.
//   clk, rst_n : clock, async active-low reset (pc <= RESET_PC)
//   load       : pc <= load_val (takes priority over inc)
//   inc        : pc <= pc + PC_INC, wrapping modulo 2^PC_W
//   pc, pc_plus: current PC and PC + PC_INC
module fetch_pc_reg
    import step1_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [PC_W-1:0] PC_INC   = DEF_PC_INC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    input  logic            inc,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus
);

    // Same-width add drops the carry, giving the natural 16-bit wrap.
    assign pc_plus = pc + PC_INC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    pc <= RESET_PC;
        else if (load) pc <= load_val;
        else if (inc)  pc <= pc_plus;
    end

endmodule

// File: rtl/step1_fetch.sv
// step1_fetch: instruction-fetch stage feeding step2.
//   CLK, RST_N  : clock, async active-low reset
//   mem         : instruction-memory bus (master side)
//   fetchEn     : start a fetch at the current PC (honoured in IDLE only)
//   PCWrite     : load PC from PCNext (redirect)
//   PCNext      : redirect target
//   instruction : last fetched word          -> step2.instruction
//   instrPC     : address of that word       -> step2.PC
//   instrWrite  : one-cycle "new instruction" -> step2.instrWrite
//   busy        : fetch in progress (REQ or DONE)
//   fault       : sticky misaligned-PC flag
module step1_fetch
    import step1_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [PC_W-1:0] PC_INC   = DEF_PC_INC
) (
    input  logic            CLK,
    input  logic            RST_N,
    step1_fetch_if.master   mem,
    input  logic            fetchEn,
    input  logic            PCWrite,
    input  logic [PC_W-1:0] PCNext,
    output logic [15:0]     instruction,
    output logic [PC_W-1:0] instrPC,
    output logic            instrWrite,
    output logic            busy,
    output logic            fault
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc, pc_plus;
    logic            pc_load, pc_inc;
    logic [PC_W-1:0] pc_load_val;
    logic            capture;
    logic            fault_d;
    logic            pend_q, pend_d;       // redirect seen while REQ
    logic [PC_W-1:0] tgt_q, tgt_d;         // its target
    logic            redirect;
    logic [PC_W-1:0] redirect_tgt;

    fetch_pc_reg #(.RESET_PC(RESET_PC), .PC_INC(PC_INC)) u_pc (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (pc_load),
        .load_val (pc_load_val),
        .inc      (pc_inc),
        .pc       (pc),
        .pc_plus  (pc_plus)
    );

    // A PCWrite arriving together with memReady is newer than any latched
    // target, so it wins.
    assign redirect     = PCWrite | pend_q;
    assign redirect_tgt = PCWrite ? PCNext : tgt_q;

    always_comb begin
        state_d     = state_q;
        pc_load     = 1'b0;
        pc_load_val = PCNext;
        pc_inc      = 1'b0;
        capture     = 1'b0;
        fault_d     = fault;
        pend_d      = pend_q;
        tgt_d       = tgt_q;
        case (state_q)
            IDLE: begin
                if (PCWrite) begin
                    pc_load = 1'b1;
                    fault_d = PCNext[0];
                end else if (fetchEn) begin
                    if (pc[0]) fault_d = 1'b1;
                    else       state_d = REQ;
                end
            end
            REQ: begin
                if (mem.memReady) begin
                    if (redirect) begin
                        // Returned word belongs to the abandoned path.
                        pc_load     = 1'b1;
                        pc_load_val = redirect_tgt;
                        fault_d     = redirect_tgt[0];
                        pend_d      = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        capture = 1'b1;
                        pc_inc  = 1'b1;
                        state_d = DONE;
                    end
                end else if (PCWrite) begin
                    // PC must stay put while the request is outstanding.
                    pend_d = 1'b1;
                    tgt_d  = PCNext;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (PCWrite) begin
                    pc_load = 1'b1;
                    fault_d = PCNext[0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            fault       <= 1'b0;
            pend_q      <= 1'b0;
            tgt_q       <= '0;
            instruction <= '0;
            instrPC     <= '0;
        end else begin
            state_q <= state_d;
            fault   <= fault_d;
            pend_q  <= pend_d;
            tgt_q   <= tgt_d;
            if (capture) begin
                instruction <= mem.memData;
                instrPC     <= pc;
            end
        end
    end

    // Decoded straight from the state register, so memReq falls with the
    // asynchronous reset.
    assign mem.memReq  = (state_q == REQ);
    assign mem.memAddr = pc;
    assign instrWrite  = (state_q == DONE);
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_step1_fetch.sv
module tb_step1_fetch;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        fetchEn, PCWrite;
    logic [15:0] PCNext;
    logic [15:0] instruction, instrPC;
    logic        instrWrite, busy, fault;

    step1_fetch_if mem ();

    step1_fetch dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .mem         (mem),
        .fetchEn     (fetchEn),
        .PCWrite     (PCWrite),
        .PCNext      (PCNext),
        .instruction (instruction),
        .instrPC     (instrPC),
        .instrWrite  (instrWrite),
        .busy        (busy),
        .fault       (fault)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Transaction-level model: architectural state only.
    logic [15:0] m_pc, m_instr, m_ipc;
    logic        m_fault;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".memReq"},      {31'd0, mem.memReq}, 32'd0);
        chk({tag, ".busy"},        {31'd0, busy},       32'd0);
        chk({tag, ".instrWrite"},  {31'd0, instrWrite}, 32'd0);
        chk({tag, ".memAddr"},     {16'd0, mem.memAddr}, {16'd0, m_pc});
        chk({tag, ".instruction"}, {16'd0, instruction}, {16'd0, m_instr});
        chk({tag, ".instrPC"},     {16'd0, instrPC},    {16'd0, m_ipc});
        chk({tag, ".fault"},       {31'd0, fault},      {31'd0, m_fault});
    endtask

    task automatic pc_write(input logic [15:0] v);
        PCWrite = 1'b1;
        PCNext  = v;
        tick();
        PCWrite = 1'b0;
        PCNext  = 16'($urandom);
        m_pc    = v;
        m_fault = v[0];
        check_idle("pcw");
    endtask

    // One fetch from IDLE at an aligned PC. stalls = cycles of memReady low.
    // redir_at >= 0 asserts PCWrite in that response cycle (stalls == the
    // completion cycle); decoy adds an earlier PCWrite that must be overridden.
    task automatic do_fetch(input int stalls, input logic [15:0] data,
                            input int redir_at, input logic [15:0] redir_tgt,
                            input logic decoy);
        logic [15:0] nxt;
        fetchEn = 1'b1;
        tick();
        fetchEn = 1'b0;
        chk("req.memReq",  {31'd0, mem.memReq}, 32'd1);
        chk("req.busy",    {31'd0, busy},       32'd1);
        chk("req.memAddr", {16'd0, mem.memAddr}, {16'd0, m_pc});
        for (int s = 0; s <= stalls; s++) begin
            mem.memReady = (s == stalls);
            mem.memData  = (s == stalls) ? data : 16'($urandom);
            if (s == redir_at) begin
                PCWrite = 1'b1;
                PCNext  = redir_tgt;
            end else if (decoy && s == 0 && redir_at > 0) begin
                PCWrite = 1'b1;
                PCNext  = ~redir_tgt;
            end
            tick();
            mem.memReady = 1'b0;
            PCWrite      = 1'b0;
            if (s < stalls) begin
                chk("stall.memReq",     {31'd0, mem.memReq}, 32'd1);
                chk("stall.memAddr",    {16'd0, mem.memAddr}, {16'd0, m_pc});
                chk("stall.instrWrite", {31'd0, instrWrite}, 32'd0);
            end
        end
        if (redir_at >= 0) begin
            m_pc    = redir_tgt;
            m_fault = redir_tgt[0];
            check_idle("redir");
        end else begin
            nxt = m_pc + 16'd2;
            chk("done.instrWrite",  {31'd0, instrWrite}, 32'd1);
            chk("done.instruction", {16'd0, instruction}, {16'd0, data});
            chk("done.instrPC",     {16'd0, instrPC},    {16'd0, m_pc});
            chk("done.memAddr",     {16'd0, mem.memAddr}, {16'd0, nxt});
            chk("done.memReq",      {31'd0, mem.memReq}, 32'd0);
            m_instr = data;
            m_ipc   = m_pc;
            m_pc    = nxt;
            tick();
            check_idle("post");
        end
    endtask

    task automatic misaligned_fetch();
        fetchEn = 1'b1;
        tick();
        fetchEn = 1'b0;
        m_fault = 1'b1;
        check_idle("misal");
    endtask

    initial begin
        logic [15:0] d, t;
        int          op;
        RST_N        = 1'b0;
        fetchEn      = 1'b0;
        PCWrite      = 1'b0;
        PCNext       = 16'h0;
        mem.memReady = 1'b0;
        mem.memData  = 16'h0;
        m_pc = 16'h0; m_instr = 16'h0; m_ipc = 16'h0; m_fault = 1'b0;

        #12;
        check_idle("reset");
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        check_idle("rel");

        // Basic fetch, then a 3-cycle stall.
        do_fetch(0, 16'd534, -1, 16'h0, 1'b0);
        do_fetch(3, 16'hA5A5, -1, 16'h0, 1'b0);

        // Wrap at the top of the address space.
        pc_write(16'hFFFE);
        do_fetch(0, 16'h1234, -1, 16'h0, 1'b0);

        // Redirect during a stall, and one coinciding with memReady.
        do_fetch(2, 16'hBEEF, 1, 16'h0040, 1'b0);
        do_fetch(1, 16'hCAFE, 1, 16'h0080, 1'b0);
        do_fetch(3, 16'hDEAD, 2, 16'h0100, 1'b1);

        // Misaligned PC: fetch refused, fault sticky until aligned load.
        pc_write(16'h0003);
        misaligned_fetch();
        tick();
        check_idle("misal2");
        pc_write(16'h0004);

        // memReady outside REQ is ignored.
        mem.memReady = 1'b1;
        mem.memData  = 16'h7777;
        tick();
        mem.memReady = 1'b0;
        check_idle("idle_rdy");

        // PCWrite beats fetchEn in IDLE.
        PCWrite = 1'b1; fetchEn = 1'b1; PCNext = 16'h0010;
        tick();
        PCWrite = 1'b0; fetchEn = 1'b0;
        m_pc = 16'h0010;
        check_idle("prio");

        // PCWrite during DONE loads the PC.
        fetchEn = 1'b1;
        tick();
        fetchEn = 1'b0;
        mem.memReady = 1'b1; mem.memData = 16'h4242;
        tick();
        mem.memReady = 1'b0;
        chk("donepcw.instrWrite", {31'd0, instrWrite}, 32'd1);
        PCWrite = 1'b1; PCNext = 16'h0022;
        tick();
        PCWrite = 1'b0;
        m_instr = 16'h4242; m_ipc = 16'h0010; m_pc = 16'h0022; m_fault = 1'b0;
        check_idle("donepcw");

        // Randomized mix.
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 5));
            d  = 16'($urandom);
            t  = 16'($urandom);
            if (op == 0) begin
                pc_write(t);
            end else if (m_pc[0]) begin
                misaligned_fetch();
                pc_write({t[15:1], 1'b0});
            end else if (op == 1) begin
                if ($urandom_range(0, 3) != 0) t[0] = 1'b0;
                begin
                    int st;
                    st = int'($urandom_range(0, 4));
                    do_fetch(st, d, int'($urandom_range(0, st)), t, 1'($urandom));
                end
            end else begin
                do_fetch(int'($urandom_range(0, 4)), d, -1, 16'h0, 1'b0);
            end
        end

        // Asynchronous reset in the middle of a request.
        if (m_pc[0]) pc_write(16'h0200);
        fetchEn = 1'b1;
        tick();
        fetchEn = 1'b0;
        chk("arst.pre_memReq", {31'd0, mem.memReq}, 32'd1);
        #2 RST_N = 1'b0;
        #1;
        chk("arst.memReq", {31'd0, mem.memReq}, 32'd0);
        chk("arst.busy",   {31'd0, busy},       32'd0);
        m_pc = 16'h0; m_instr = 16'h0; m_ipc = 16'h0; m_fault = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        check_idle("arst");
        do_fetch(0, 16'h0909, -1, 16'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
